// File: rtl/dcsformer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcsformer_pkg
// Purpose  : Shared state encoding, arithmetic mode flag and the H-entry
//            width helper for the DCSformer attention-score block.
// Macro    : DCSF_SIGNED_EN - when defined, matrix and weight elements are
//            two's complement and all H/out arithmetic is signed.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package dcsformer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_LOAD  = 2'd0;
    localparam state_t c_ST_PRUNE = 2'd1;
    localparam state_t c_ST_WLOAD = 2'd2;
    localparam state_t c_ST_OUT   = 2'd3;

`ifdef DCSF_SIGNED_EN
    localparam logic c_SIGNED = 1'b1;
`else
    localparam logic c_SIGNED = 1'b0;
`endif

    // Width of one Gram-matrix entry: a full DW x DW product summed COLS times.
    function automatic int gw(input int dw, input int cols);
        return 2 * dw + $clog2(cols);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcsformer_param_if.sv
`default_nettype none
// ============================================================================
// Module   : dcsformer_param_if
// Purpose  : Handshake bundle of the DCSformer block: matrix input stream,
//            weight input stream and result output stream.
// Ports    : i_valid/i_ready/i_data  - matrix element stream (into block)
//            w_valid/w_ready/w_data  - weight stream (into block)
//            o_valid/o_ready/o_data  - result stream (out of block)
// Modports : slave  - the DCSformer block side
//            master - the producer/consumer side
// Revision : 1.0 - initial parametrised release
// ============================================================================
interface dcsformer_param_if #(
    parameter int DW = 8,
    parameter int OW = 32
);
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_data;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] w_data;
    logic          o_valid;
    logic          o_ready;
    logic [OW-1:0] o_data;

    modport slave (
        input  i_valid, i_data, w_valid, w_data, o_ready,
        output i_ready, w_ready, o_valid, o_data
    );

    modport master (
        output i_valid, i_data, w_valid, w_data, o_ready,
        input  i_ready, w_ready, o_valid, o_data
    );
endinterface
`default_nettype wire

// File: rtl/dcsf_row_prune.sv
`default_nettype none
// ============================================================================
// Module   : dcsf_row_prune
// Purpose  : Combinational pruning of one Gram-matrix row. Computes the row
//            floor mean and zeroes every entry strictly below it.
// Ports    : i_row - ROWS entries of GW bits (one row of H)
//            o_row - pruned row
// Macro    : DCSF_SIGNED_EN selects signed sum, arithmetic shift and signed
//            comparison.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module dcsf_row_prune
    import dcsformer_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int GW   = 20
) (
    input  logic [ROWS-1:0][GW-1:0] i_row,
    output logic [ROWS-1:0][GW-1:0] o_row
);

    localparam int c_LR = $clog2(ROWS);
    localparam int c_SW = GW + c_LR;

    logic [c_SW-1:0] w_ext [ROWS];
    logic [c_SW-1:0] w_sum;
    logic [c_SW-1:0] w_avg;

    for (genvar j = 0; j < ROWS; j++) begin : g_ext
        assign w_ext[j] = {{c_LR{c_SIGNED & i_row[j][GW-1]}}, i_row[j]};
    end

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < ROWS; j++) begin
            w_sum = w_sum + w_ext[j];
        end
    end

    // Signed mode: >>> floors toward -inf, matching the floor-mean definition.
    if (c_SIGNED) begin : g_signed
        assign w_avg = $signed(w_sum) >>> c_LR;
        for (genvar j = 0; j < ROWS; j++) begin : g_cmp
            assign o_row[j] = ($signed(w_ext[j]) < $signed(w_avg)) ? '0 : i_row[j];
        end
    end else begin : g_unsigned
        assign w_avg = w_sum >> c_LR;
        for (genvar j = 0; j < ROWS; j++) begin : g_cmp
            assign o_row[j] = (w_ext[j] < w_avg) ? '0 : i_row[j];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcsformer_param.sv
`default_nettype none
// ============================================================================
// Module   : dcsformer_param
// Purpose  : DCSformer attention-score block. Streams in a ROWS x COLS
//            matrix X row-major, accumulates H = X*X^T on the fly, prunes
//            each row of H below its floor mean, multiplies by a ROWS-element
//            weight vector and streams ROWS results out.
// Ports    : clk   - clock
//            rst_n - asynchronous active-low reset
//            bus   - dcsformer_param_if.slave (matrix, weight, result streams)
//            busy  - low only in LOAD before the first element of a frame
// Macro    : DCSF_SIGNED_EN - two's complement operands and signed H/out.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module dcsformer_param
    import dcsformer_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 16,
    parameter int DW   = 8,
    parameter int OW   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dcsformer_param_if.slave        bus,
    output logic                    busy
);

    localparam int c_GW = gw(DW, COLS);
    localparam int c_LR = $clog2(ROWS);
    localparam int c_CW = (COLS > 1) ? $clog2(COLS) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [c_LR-1:0]     r_row;
    logic [c_CW-1:0]     r_col;
    logic [c_LR-1:0]     r_wcnt;
    logic [c_LR-1:0]     r_ocnt;

    logic [DW-1:0]                   r_x   [ROWS][COLS];
    logic [ROWS-1:0][c_GW-1:0]       r_h   [ROWS];
    logic [ROWS-1:0][c_GW-1:0]       w_h_pruned [ROWS];
    logic [OW-1:0]                   r_out [ROWS];

    logic [c_GW-1:0]     w_xin;
    logic [c_GW-1:0]     w_prod  [ROWS];
    logic [OW-1:0]       w_wext;
    logic [OW-1:0]       w_oprod [ROWS];

    logic                w_in_fire;
    logic                w_w_fire;
    logic                w_o_fire;
    logic                w_last_in;
    logic                w_last_w;
    logic                w_last_o;

    assign w_in_fire = bus.i_valid & bus.i_ready;
    assign w_w_fire  = bus.w_valid & bus.w_ready;
    assign w_o_fire  = bus.o_valid & bus.o_ready;
    assign w_last_in = (r_row == c_LR'(ROWS - 1)) && (r_col == c_CW'(COLS - 1));
    assign w_last_w  = (r_wcnt == c_LR'(ROWS - 1));
    assign w_last_o  = (r_ocnt == c_LR'(ROWS - 1));

    // ------------------------------------------------------------------
    // Products for the incoming element x at (r,c): prod[k] = X[k][c]*x.
    // Row r itself is not yet stored, so the diagonal term uses x directly.
    // Truncation to c_GW bits is exact in both signed and unsigned modes.
    // ------------------------------------------------------------------
    assign w_xin = {{(c_GW - DW){c_SIGNED & bus.i_data[DW-1]}}, bus.i_data};

    for (genvar k = 0; k < ROWS; k++) begin : g_prod
        logic [DW-1:0] w_xk;
        assign w_xk      = (r_row == c_LR'(k)) ? bus.i_data : r_x[k][r_col];
        assign w_prod[k] = {{(c_GW - DW){c_SIGNED & w_xk[DW-1]}}, w_xk} * w_xin;
    end

    // Weight contribution for column r_wcnt; modulo-2^OW arithmetic.
    assign w_wext = {{(OW - DW){c_SIGNED & bus.w_data[DW-1]}}, bus.w_data};

    for (genvar i = 0; i < ROWS; i++) begin : g_wprod
        logic [c_GW-1:0] w_hsel;
        assign w_hsel     = r_h[i][r_wcnt];
        assign w_oprod[i] = {{(OW - c_GW){c_SIGNED & w_hsel[c_GW-1]}}, w_hsel} * w_wext;
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_prune
        dcsf_row_prune #(
            .ROWS (ROWS),
            .GW   (c_GW)
        ) u_row_prune (
            .i_row (r_h[i]),
            .o_row (w_h_pruned[i])
        );
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_LOAD:  if (w_in_fire && w_last_in) w_next = c_ST_PRUNE;
            c_ST_PRUNE: w_next = c_ST_WLOAD;
            c_ST_WLOAD: if (w_w_fire && w_last_w)   w_next = c_ST_OUT;
            c_ST_OUT:   if (w_o_fire && w_last_o)   w_next = c_ST_LOAD;
            default:    w_next = c_ST_LOAD;
        endcase
    end

    // FSM: outputs. o_data is driven only in OUT so it reads zero otherwise.
    always_comb begin
        bus.i_ready = (r_state == c_ST_LOAD);
        bus.w_ready = (r_state == c_ST_WLOAD);
        bus.o_valid = (r_state == c_ST_OUT);
        bus.o_data  = (r_state == c_ST_OUT) ? r_out[r_ocnt] : '0;
        busy        = !((r_state == c_ST_LOAD) && (r_row == '0) && (r_col == '0));
    end

    // ------------------------------------------------------------------
    // X buffer: written only on accepted beats, never read before written.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_x[r_row][r_col] <= bus.i_data;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: H accumulation, pruning, weight MAC, output sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row  <= '0;
            r_col  <= '0;
            r_wcnt <= '0;
            r_ocnt <= '0;
            for (int i = 0; i < ROWS; i++) begin
                r_out[i] <= '0;
                r_h[i]   <= '0;
            end
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    if (w_in_fire) begin
                        // Row r gets prod[j] for j<=r; column r mirrors it for i<r.
                        for (int i = 0; i < ROWS; i++) begin
                            for (int j = 0; j < ROWS; j++) begin
                                if ((r_row == c_LR'(i)) && (c_LR'(j) <= r_row)) begin
                                    r_h[i][j] <= r_h[i][j] + w_prod[j];
                                end else if ((r_row == c_LR'(j)) && (c_LR'(i) < r_row)) begin
                                    r_h[i][j] <= r_h[i][j] + w_prod[i];
                                end
                            end
                        end
                        if (r_col == c_CW'(COLS - 1)) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                c_ST_PRUNE: begin
                    for (int i = 0; i < ROWS; i++) begin
                        r_h[i] <= w_h_pruned[i];
                    end
                end
                c_ST_WLOAD: begin
                    if (w_w_fire) begin
                        for (int i = 0; i < ROWS; i++) begin
                            r_out[i] <= r_out[i] + w_oprod[i];
                        end
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                c_ST_OUT: begin
                    if (w_o_fire) begin
                        if (w_last_o) begin
                            // Clear everything so the next frame starts clean.
                            r_row  <= '0;
                            r_col  <= '0;
                            r_wcnt <= '0;
                            r_ocnt <= '0;
                            for (int i = 0; i < ROWS; i++) begin
                                r_out[i] <= '0;
                                r_h[i]   <= '0;
                            end
                        end else begin
                            r_ocnt <= r_ocnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcsformer_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcsformer_param
// Purpose  : Directed self-checking bench for dcsformer_param (8x16, DW=8,
//            OW=32). Inputs driven on the falling edge, outputs sampled on
//            the falling edge.
// Macro    : DCSF_SIGNED_EN changes the expected result of the max-value frame.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module tb_dcsformer_param;

    localparam int ROWS = 8;
    localparam int COLS = 16;
    localparam int BUDGET = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    always #5 clk = ~clk;

    dcsformer_param_if #(.DW(8), .OW(32)) bus ();

    dcsformer_param #(
        .ROWS (ROWS),
        .COLS (COLS),
        .DW   (8),
        .OW   (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  xm [ROWS][COLS];
    logic [7:0]  wv [ROWS];
    logic [31:0] ev [ROWS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge after the transfer.
    task automatic send_x();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int n;
                bus.i_valid = 1'b1;
                bus.i_data  = xm[r][c];
                n = 0;
                while (!bus.i_ready && n < BUDGET) begin
                    @(negedge clk);
                    n++;
                end
                chk("i_ready_wait", {31'd0, bus.i_ready}, 32'd1);
                @(negedge clk);
            end
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic send_w(input int count);
        for (int k = 0; k < count; k++) begin
            int n;
            bus.w_valid = 1'b1;
            bus.w_data  = wv[k];
            n = 0;
            while (!bus.w_ready && n < BUDGET) begin
                @(negedge clk);
                n++;
            end
            chk("w_ready_wait", {31'd0, bus.w_ready}, 32'd1);
            @(negedge clk);
        end
        bus.w_valid = 1'b0;
    endtask

    task automatic recv(input int stall_idx);
        for (int k = 0; k < ROWS; k++) begin
            int n;
            bus.o_ready = (k != stall_idx);
            n = 0;
            while (!bus.o_valid && n < BUDGET) begin
                @(negedge clk);
                n++;
            end
            chk("o_valid_wait", {31'd0, bus.o_valid}, 32'd1);
            if (k == stall_idx) begin
                for (int s = 0; s < 3; s++) begin
                    chk($sformatf("stall_data%0d", s), bus.o_data, ev[k]);
                    chk($sformatf("stall_valid%0d", s), {31'd0, bus.o_valid}, 32'd1);
                    @(negedge clk);
                end
                bus.o_ready = 1'b1;
            end
            chk($sformatf("out%0d", k), bus.o_data, ev[k]);
            @(negedge clk);
        end
        bus.o_ready = 1'b0;
        chk("end_o_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("end_o_data", bus.o_data, 32'd0);
        chk("end_i_ready", {31'd0, bus.i_ready}, 32'd1);
        chk("end_busy", {31'd0, busy}, 32'd0);
    endtask

    // junk=1 drives stray weights during LOAD and stray elements during WLOAD.
    task automatic run_frame(input int stall_idx, input bit junk);
        if (junk) begin
            bus.w_valid = 1'b1;
            bus.w_data  = 8'h77;
        end
        send_x();
        if (junk) begin
            bus.i_valid = 1'b1;
            bus.i_data  = 8'hAA;
        end
        send_w(ROWS);
        bus.i_valid = 1'b0;
        recv(stall_idx);
    endtask

    task automatic set_ones();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) xm[r][c] = 8'd1;
            wv[r] = 8'd1;
            ev[r] = 32'd128;
        end
    endtask

    task automatic set_diag();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) xm[r][c] = (c == r) ? 8'(r + 1) : 8'd0;
            wv[r] = 8'(r + 1);
            ev[r] = 32'((r + 1) * (r + 1) * (r + 1));
        end
    endtask

    task automatic set_prune();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) xm[r][c] = ((r == 0) || (c == 0)) ? 8'd1 : 8'd0;
            wv[r] = 8'd1;
            ev[r] = (r == 0) ? 32'd16 : 32'd8;
        end
    endtask

    task automatic set_max();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) xm[r][c] = 8'hFF;
            wv[r] = 8'hFF;
`ifdef DCSF_SIGNED_EN
            ev[r] = 32'hFFFF_FF80;
`else
            ev[r] = 32'd2122416000;
`endif
        end
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        bus.o_ready = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_i_ready", {31'd0, bus.i_ready}, 32'd1);
        chk("rst_w_ready", {31'd0, bus.w_ready}, 32'd0);
        chk("rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_o_data", bus.o_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // All ones, with a busy check after the matrix is loaded.
        set_ones();
        send_x();
        chk("busy_prune", {31'd0, busy}, 32'd1);
        chk("i_ready_prune", {31'd0, bus.i_ready}, 32'd0);
        send_w(ROWS);
        chk("busy_out", {31'd0, busy}, 32'd1);
        recv(-1);

        // Diagonal with stall on out[2] and stray inputs, then a clean repeat.
        set_diag();
        run_frame(2, 1'b1);
        run_frame(-1, 1'b0);

        // Pruning of row 0.
        set_prune();
        run_frame(-1, 1'b0);

        // Maximum values.
        set_max();
        run_frame(-1, 1'b0);

        // Reset mid-WLOAD after 3 weights, then a fresh frame.
        set_max();
        send_x();
        send_w(3);
        rst_n = 1'b0;
        #1;
        chk("midrst_w_ready", {31'd0, bus.w_ready}, 32'd0);
        chk("midrst_i_ready", {31'd0, bus.i_ready}, 32'd1);
        chk("midrst_o_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("midrst_w_ready2", {31'd0, bus.w_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        set_prune();
        run_frame(-1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
